// File: rtl/instr_fetch_unit.sv
//==============================================================================
// Module      : instr_fetch_unit
// Description : Program counter, instruction-memory requester and instruction
//               register feeding the CPU control FSM. Fetches the word at pc
//               over a req/ack port, latches it into the IR, and applies the
//               controller's pc_en / pc_load / halt commands. A fetch that
//               never sees an ack is abandoned after TIMEOUT cycles and a HLT
//               opcode is injected so the controller stops cleanly.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_fetch_en         - permits starting a fetch (from IDLE)
//               i_pc_en            - advance pc by 1 (in HOLD)
//               i_pc_load          - jump to operand (OP_JMP) or skip pc+2
//               i_halt             - stop fetching until reset
//               o_imem_req/addr    - memory request and address
//               i_imem_ack/rdata   - memory response
//               o_opcode/o_operand - IR fields
//               o_ir_valid         - IR holds the word fetched from pc
//               o_pc               - program counter
//               o_halted           - unit is halted
//               o_fetch_err        - sticky fetch-timeout flag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15,
  parameter int OP_JMP  = 7,
  parameter int OP_HLT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_fetch_en,
  input  logic                   i_pc_en,
  input  logic                   i_pc_load,
  input  logic                   i_halt,
  output logic                   o_imem_req,
  output logic [ADDR_W-1:0]      o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [OP_W+ADDR_W-1:0] i_imem_rdata,
  output logic [OP_W-1:0]        o_opcode,
  output logic [ADDR_W-1:0]      o_operand,
  output logic                   o_ir_valid,
  output logic [ADDR_W-1:0]      o_pc,
  output logic                   o_halted,
  output logic                   o_fetch_err
);

  localparam int c_WORD_W = OP_W + ADDR_W;
  // Keep the counter at least one bit wide so TIMEOUT=1 still elaborates.
  localparam int c_TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [c_WORD_W-1:0]  r_ir;
  logic                 r_ir_valid;
  logic                 r_imem_req;
  logic [ADDR_W-1:0]    r_imem_addr;
  logic                 r_halted;
  logic                 r_fetch_err;
  logic                 r_halt_pending;
  logic [c_TMO_W-1:0]   r_tmo_cnt;

  logic                 w_tmo_hit;
  logic                 w_is_jmp;
  logic [c_WORD_W-1:0]  w_hlt_word;

  // Last REQ cycle allowed without an ack; an ack in that same cycle still wins.
  assign w_tmo_hit  = (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
  assign w_is_jmp   = (r_ir[c_WORD_W-1:ADDR_W] == OP_W'(OP_JMP));
  assign w_hlt_word = {OP_W'(OP_HLT), {ADDR_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_ir           <= '0;
      r_ir_valid     <= 1'b0;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= '0;
      r_halted       <= 1'b0;
      r_fetch_err    <= 1'b0;
      r_halt_pending <= 1'b0;
      r_tmo_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (i_fetch_en) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
            r_tmo_cnt   <= '0;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          // The request is never withdrawn early; a halt here is deferred
          // until the word (or the injected HLT) has been captured.
          if (i_halt) begin
            r_halt_pending <= 1'b1;
          end
          if (i_imem_ack || w_tmo_hit) begin
            r_ir       <= i_imem_ack ? i_imem_rdata : w_hlt_word;
            r_ir_valid <= 1'b1;
            r_imem_req <= 1'b0;
            if (!i_imem_ack) begin
              r_fetch_err <= 1'b1;
            end
            if (r_halt_pending || i_halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_HOLD;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
          end
        end

        S_HOLD: begin
          if (i_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (i_pc_load) begin
            r_pc       <= w_is_jmp ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(2);
            r_ir_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_pc_en) begin
            r_pc       <= r_pc + ADDR_W'(1);
            r_ir_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        S_HALTED: begin
          // Terminal until reset: everything frozen.
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_imem_addr;
  assign o_opcode    = r_ir[c_WORD_W-1:ADDR_W];
  assign o_operand   = r_ir[ADDR_W-1:0];
  assign o_ir_valid  = r_ir_valid;
  assign o_pc        = r_pc;
  assign o_halted    = r_halted;
  assign o_fetch_err = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//==============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A transaction-level
//               model tracks the program counter, last fetched word and the
//               sticky error flag; randomized fetch latencies, words and
//               controller commands are compared against it.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

  localparam int AW   = 5;
  localparam int OW   = 3;
  localparam int TMO  = 15;
  localparam int JMP  = 7;
  localparam int HLT  = 0;
  localparam int PCM  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en, pc_en, pc_load, halt;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [7:0]    imem_rdata;
  logic [OW-1:0] opcode;
  logic [AW-1:0] operand;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_pc;
  int m_op;
  int m_opd;
  bit m_err;

  instr_fetch_unit #(
    .ADDR_W (AW),
    .OP_W   (OW),
    .TIMEOUT(TMO),
    .OP_JMP (JMP),
    .OP_HLT (HLT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_en  (fetch_en),
    .i_pc_en     (pc_en),
    .i_pc_load   (pc_load),
    .i_halt      (halt),
    .o_imem_req  (imem_req),
    .o_imem_addr (imem_addr),
    .i_imem_ack  (imem_ack),
    .i_imem_rdata(imem_rdata),
    .o_opcode    (opcode),
    .o_operand   (operand),
    .o_ir_valid  (ir_valid),
    .o_pc        (pc),
    .o_halted    (halted),
    .o_fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    fetch_en = 1'b0; pc_en = 1'b0; pc_load = 1'b0; halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    check_eq("rst_pc",       pc,        0);
    check_eq("rst_req",      imem_req,  0);
    check_eq("rst_addr",     imem_addr, 0);
    check_eq("rst_irv",      ir_valid,  0);
    check_eq("rst_opcode",   opcode,    0);
    check_eq("rst_operand",  operand,   0);
    check_eq("rst_halted",   halted,    0);
    check_eq("rst_fetcherr", fetch_err, 0);
    rst = 1'b0;
    m_pc = 0; m_op = 0; m_opd = 0; m_err = 1'b0;
  endtask

  // One fetch from IDLE. lat = ack-less cycles before the ack; tmo forces a
  // dead memory; halt_req raises halt once in the first REQ cycle.
  task automatic fetch(input int lat, input logic [7:0] word, input bit tmo, input bit halt_req);
    int n;
    clear_inputs();
    fetch_en   = 1'b1;
    imem_ack   = 1'($urandom_range(0, 1));  // ignored in IDLE
    imem_rdata = 8'($urandom);
    step();
    check_eq("req_start", imem_req,  1);
    check_eq("req_addr",  imem_addr, m_pc);
    check_eq("req_irv",   ir_valid,  0);
    n = tmo ? TMO - 1 : lat;
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      fetch_en   = 1'($urandom_range(0, 1));
      pc_en      = 1'($urandom_range(0, 1));
      pc_load    = 1'($urandom_range(0, 1));
      halt       = halt_req && (i == 0);
      step();
      check_eq("req_held", imem_req,  1);
      check_eq("addr_held", imem_addr, m_pc);
      check_eq("pc_in_req", pc, m_pc);
    end
    clear_inputs();
    if (tmo) begin
      m_op = HLT; m_opd = 0; m_err = 1'b1;
    end else begin
      imem_ack   = 1'b1;
      imem_rdata = word;
      m_op  = int'(word) / PCM;
      m_opd = int'(word) % PCM;
    end
    step();
    clear_inputs();
    check_eq("done_req",     imem_req,  0);
    check_eq("done_irv",     ir_valid,  1);
    check_eq("done_opcode",  opcode,    m_op);
    check_eq("done_operand", operand,   m_opd);
    check_eq("done_err",     fetch_err, m_err);
    check_eq("done_halted",  halted,    halt_req);
    check_eq("done_pc",      pc,        m_pc);
  endtask

  // Controller command in HOLD after `wait_cyc` idle cycles.
  // cmd: 0 pc_en, 1 pc_load, 2 pc_load+pc_en, 3 halt (+pc_load).
  task automatic hold_cmd(input int wait_cyc, input int cmd);
    for (int i = 0; i < wait_cyc; i++) begin
      fetch_en = 1'($urandom_range(0, 1));
      step();
      check_eq("hold_irv", ir_valid, 1);
      check_eq("hold_req", imem_req, 0);
      check_eq("hold_opcode", opcode, m_op);
    end
    clear_inputs();
    pc_en   = (cmd == 0 || cmd == 2);
    pc_load = (cmd != 0);
    halt    = (cmd == 3);
    step();
    clear_inputs();
    if (cmd == 3) begin
      check_eq("halt_halted", halted,   1);
      check_eq("halt_irv",    ir_valid, 1);
      check_eq("halt_pc",     pc,       m_pc);
    end else begin
      if (cmd == 0) m_pc = (m_pc + 1) % PCM;
      else if (m_op == JMP) m_pc = m_opd;
      else m_pc = (m_pc + 2) % PCM;
      check_eq("cmd_pc",  pc,       m_pc);
      check_eq("cmd_irv", ir_valid, 0);
      check_eq("cmd_req", imem_req, 0);
    end
  endtask

  // While halted nothing may move, whatever the controller asks for.
  task automatic check_halted_frozen(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      fetch_en = 1'b1;
      pc_en    = 1'($urandom_range(0, 1));
      pc_load  = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      step();
      check_eq("hlt_req",    imem_req, 0);
      check_eq("hlt_halted", halted,   1);
      check_eq("hlt_pc",     pc,       m_pc);
      check_eq("hlt_opcode", opcode,   m_op);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    do_reset();

    // Ack two cycles after the request with 0xA3: opcode 5, operand 3.
    fetch(1, 8'hA3, 1'b0, 1'b0);
    hold_cmd(2, 0);
    // Jump: opcode 7 operand 17.
    fetch(0, {3'd7, 5'd17}, 1'b0, 1'b0);
    hold_cmd(0, 1);
    check_eq("jmp_pc17", pc, 17);

    // Wrap cases: 31+1 -> 0, 30+2 -> 0, 31+2 -> 1.
    fetch(3, {3'd7, 5'd31}, 1'b0, 1'b0);
    hold_cmd(1, 1);
    fetch(2, {3'd4, 5'd9}, 1'b0, 1'b0);
    hold_cmd(0, 0);
    check_eq("wrap_pc_en", pc, 0);
    fetch(0, {3'd7, 5'd30}, 1'b0, 1'b0);
    hold_cmd(0, 2);
    fetch(1, {3'd2, 5'd5}, 1'b0, 1'b0);
    hold_cmd(0, 1);
    check_eq("wrap_skip30", pc, 0);
    fetch(0, {3'd7, 5'd31}, 1'b0, 1'b0);
    hold_cmd(0, 1);
    fetch(0, {3'd3, 5'd0}, 1'b0, 1'b0);
    hold_cmd(0, 1);
    check_eq("wrap_skip31", pc, 1);

    // Ack on the very last cycle before the timeout still wins.
    fetch(TMO - 1, 8'h5C, 1'b0, 1'b0);
    hold_cmd(0, 0);

    // Dead memory: HLT injected, error sticky across later fetches.
    fetch(0, 8'h00, 1'b1, 1'b0);
    hold_cmd(1, 0);
    fetch(2, 8'h66, 1'b0, 1'b0);
    check_eq("err_sticky", fetch_err, 1);
    hold_cmd(0, 3);
    check_halted_frozen(3);
    do_reset();

    // Halt during REQ, ack three cycles later.
    fetch(3, 8'hB5, 1'b0, 1'b1);
    check_halted_frozen(4);
    do_reset();

    // Halt in IDLE beats fetch_en.
    fetch_en = 1'b1; halt = 1'b1;
    step();
    clear_inputs();
    check_eq("idle_halt", halted, 1);
    check_eq("idle_halt_req", imem_req, 0);
    check_halted_frozen(2);
    do_reset();

    // Reset in the middle of a request.
    fetch(0, 8'h21, 1'b0, 1'b0);
    hold_cmd(0, 0);
    fetch_en = 1'b1;
    step();
    check_eq("mid_req_up", imem_req, 1);
    do_reset();
    fetch(1, 8'h47, 1'b0, 1'b0);
    hold_cmd(0, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        fetch(0, 8'h00, 1'b1, 1'b0);
        hold_cmd($urandom_range(0, 2), $urandom_range(0, 2));
      end else if (r == 1) begin
        fetch($urandom_range(1, 5), 8'($urandom), 1'b0, 1'b1);
        check_halted_frozen(2);
        do_reset();
      end else if (r == 2) begin
        fetch($urandom_range(0, 4), 8'($urandom), 1'b0, 1'b0);
        hold_cmd(1, 3);
        check_halted_frozen(2);
        do_reset();
      end else begin
        logic [7:0] w;
        w = 8'($urandom);
        if (r < 6) w[7:5] = 3'(JMP);
        fetch($urandom_range(0, 6), w, 1'b0, 1'b0);
        hold_cmd($urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
